// File: rtl/node_rx_unpacker_pkg.sv
// node_rx_unpacker_pkg
//   Shared definitions for the node receive-side unpacker.
//   - rx_state_t : receive FSM state encoding (IDLE=0, ACK=1, RECV=2, DONE=3)
//   - *_MSB/*_LSB: bit positions of the fields in the 64-bit inbound word
//   - eff_len()  : effective packet length (a seq_len of 0 counts as one word)
package node_rx_unpacker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_RECV = 2'd2,
    ST_DONE = 2'd3
  } rx_state_t;

  localparam int SRC_MSB = 63;
  localparam int SRC_LSB = 56;
  localparam int SEQ_MSB = 55;
  localparam int SEQ_LSB = 50;
  localparam int ID_MSB  = 49;
  localparam int ID_LSB  = 44;
  localparam int PAY_MSB = 31;
  localparam int PAY_LSB = 0;

  // A zero-length header still carries one word, so it is treated as length 1.
  function automatic logic [5:0] eff_len(input logic [5:0] seq_len);
    return (seq_len == 6'd0) ? 6'd1 : seq_len;
  endfunction

endpackage

// File: rtl/node_rx_unpacker_rx_watchdog.sv
// rx_watchdog
//   Idle-cycle watchdog for the receive path. Counts cycles in which
//   'enable' is high and raises 'expired' on the cycle whose clock edge
//   would bring the count to TIMEOUT, so the owner can abort on that edge.
//   Ports:
//     clk     in  clock
//     rst     in  asynchronous reset, active-low
//     enable  in  count this cycle
//     clear   in  zero the count (has priority over enable)
//     expired out combinational: this edge completes TIMEOUT idle cycles
module rx_watchdog
  import node_rx_unpacker_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  logic [7:0] count_reg;

  assign expired = enable && !clear && (count_reg == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + 8'd1;
    end
  end

endmodule

// File: rtl/node_rx_unpacker.sv
// node_rx_unpacker
//   Accepts one inbound packet at a time from the router interface, unpacks
//   the first NUM_OPS payload words into operand slots A/B/C and presents
//   them to the PE with a valid/ready handshake. Flags length mismatches,
//   header changes inside a packet and stalled packets.
//   Ports:
//     N_clk, N_rst                 clock, asynchronous active-low reset
//     Node_o_req_rx                in : IF has a packet pending
//     Node_i_ack_rx                out: one-cycle accept pulse to IF
//     Node_o_data_input[63:0]      in : {src, seq_len, id, reserved, payload}
//     Node_o_data_input_valid      in : word qualifier
//     Node_local_id[7:0]           in : this node's id (reporting only)
//     Op_A/Op_B/Op_C[31:0]         out: unpacked operands
//     Op_src[7:0], Op_id[5:0]      out: header of presented packet
//     Op_valid / Op_ready          handshake to PE
//     Err_len, Err_hdr, Err_timeout out: one-cycle registered error pulses
module node_rx_unpacker
  import node_rx_unpacker_pkg::*;
#(
  parameter int NUM_OPS = 3,
  parameter int TIMEOUT = 255
) (
  input  logic        N_clk,
  input  logic        N_rst,
  input  logic        Node_o_req_rx,
  output logic        Node_i_ack_rx,
  input  logic [63:0] Node_o_data_input,
  input  logic        Node_o_data_input_valid,
  input  logic [7:0]  Node_local_id,
  output logic [31:0] Op_A,
  output logic [31:0] Op_B,
  output logic [31:0] Op_C,
  output logic [7:0]  Op_src,
  output logic [5:0]  Op_id,
  output logic        Op_valid,
  input  logic        Op_ready,
  output logic        Err_len,
  output logic        Err_hdr,
  output logic        Err_timeout
);

  rx_state_t   state_reg;
  logic [7:0]  src_reg;
  logic [5:0]  id_reg;
  logic [5:0]  seq_len_reg;
  logic [5:0]  word_cnt_reg;
  logic        op_valid_reg;
  logic        ack_reg;
  logic        err_len_reg;
  logic        err_hdr_reg;
  logic        err_timeout_reg;
  logic [95:0] slot_bus;

  // Field views of the incoming word.
  logic [7:0]  in_src;
  logic [5:0]  in_seq_len;
  logic [5:0]  in_id;
  logic [31:0] in_payload;
  assign in_src     = Node_o_data_input[SRC_MSB:SRC_LSB];
  assign in_seq_len = Node_o_data_input[SEQ_MSB:SEQ_LSB];
  assign in_id      = Node_o_data_input[ID_MSB:ID_LSB];
  assign in_payload = Node_o_data_input[PAY_MSB:PAY_LSB];

  // Local id and reserved header bits are carried for reporting only.
  logic unused_bits;
  assign unused_bits = ^{Node_local_id, Node_o_data_input[43:32]};

  logic       word_accept;
  logic       first_word;
  logic [5:0] cur_seq_len;
  logic [6:0] cnt_inc;
  logic       last_word;
  logic       hdr_mismatch;
  logic       wd_expired;

  assign word_accept = (state_reg == ST_RECV) && Node_o_data_input_valid;
  assign first_word  = (word_cnt_reg == 6'd0);
  // The first word defines the packet length before it is latched.
  assign cur_seq_len = first_word ? in_seq_len : seq_len_reg;
  assign cnt_inc     = {1'b0, word_cnt_reg} + 7'd1;
  assign last_word   = (cnt_inc >= {1'b0, eff_len(cur_seq_len)});
  assign hdr_mismatch = !first_word &&
                        ((in_src != src_reg) || (in_id != id_reg) ||
                         (in_seq_len != seq_len_reg));

  rx_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (N_clk),
    .rst     (N_rst),
    .enable  ((state_reg == ST_RECV) && !Node_o_data_input_valid),
    .clear   ((state_reg != ST_RECV) || word_accept),
    .expired (wd_expired)
  );

  // Operand slots: word k lands in slot k; slots beyond NUM_OPS stay zero.
  // Slots are cleared on the ACK->RECV edge so unwritten ones read 0.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_slot
      if (gi < NUM_OPS) begin : g_store
        logic [31:0] slot_reg;
        always_ff @(posedge N_clk or negedge N_rst) begin
          if (!N_rst) begin
            slot_reg <= '0;
          end else if (state_reg == ST_ACK) begin
            slot_reg <= '0;
          end else if (word_accept && (word_cnt_reg == 6'(gi))) begin
            slot_reg <= in_payload;
          end
        end
        assign slot_bus[gi*32 +: 32] = slot_reg;
      end else begin : g_none
        assign slot_bus[gi*32 +: 32] = '0;
      end
    end
  endgenerate

  always_ff @(posedge N_clk or negedge N_rst) begin
    if (!N_rst) begin
      state_reg       <= ST_IDLE;
      src_reg         <= '0;
      id_reg          <= '0;
      seq_len_reg     <= '0;
      word_cnt_reg    <= '0;
      op_valid_reg    <= 1'b0;
      ack_reg         <= 1'b0;
      err_len_reg     <= 1'b0;
      err_hdr_reg     <= 1'b0;
      err_timeout_reg <= 1'b0;
    end else begin
      ack_reg         <= 1'b0;
      err_len_reg     <= 1'b0;
      err_hdr_reg     <= 1'b0;
      err_timeout_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (Node_o_req_rx) begin
            state_reg <= ST_ACK;
            ack_reg   <= 1'b1;
          end
        end
        ST_ACK: begin
          state_reg    <= ST_RECV;
          word_cnt_reg <= '0;
        end
        ST_RECV: begin
          if (Node_o_data_input_valid) begin
            word_cnt_reg <= cnt_inc[5:0];
            if (first_word) begin
              src_reg     <= in_src;
              id_reg      <= in_id;
              seq_len_reg <= in_seq_len;
            end
            err_hdr_reg <= hdr_mismatch;
            if (last_word) begin
              state_reg    <= ST_DONE;
              op_valid_reg <= 1'b1;
              err_len_reg  <= (cur_seq_len != 6'(NUM_OPS));
            end
          end else if (wd_expired) begin
            state_reg       <= ST_IDLE;
            err_timeout_reg <= 1'b1;
          end
        end
        ST_DONE: begin
          if (op_valid_reg && Op_ready) begin
            op_valid_reg <= 1'b0;
            state_reg    <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign Node_i_ack_rx = ack_reg;
  assign Op_A          = slot_bus[31:0];
  assign Op_B          = slot_bus[63:32];
  assign Op_C          = slot_bus[95:64];
  assign Op_src        = src_reg;
  assign Op_id         = id_reg;
  assign Op_valid      = op_valid_reg;
  assign Err_len       = err_len_reg;
  assign Err_hdr       = err_hdr_reg;
  assign Err_timeout   = err_timeout_reg;

endmodule

// File: tb/tb_node_rx_unpacker.sv
// tb_node_rx_unpacker
//   Directed bench for node_rx_unpacker: normal packet, short/long packets,
//   header change, watchdog abort, PE back-pressure and mid-packet reset.
module tb_node_rx_unpacker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        ack;
  logic [63:0] data;
  logic        valid;
  logic [7:0]  local_id;
  logic [31:0] op_a, op_b, op_c;
  logic [7:0]  op_src;
  logic [5:0]  op_id;
  logic        op_valid;
  logic        op_ready;
  logic        err_len, err_hdr, err_timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_len  = 0;
  int cnt_hdr  = 0;
  int cnt_to   = 0;

  always #5 clk = ~clk;

  node_rx_unpacker dut (
    .N_clk                   (clk),
    .N_rst                   (rst_n),
    .Node_o_req_rx           (req),
    .Node_i_ack_rx           (ack),
    .Node_o_data_input       (data),
    .Node_o_data_input_valid (valid),
    .Node_local_id           (local_id),
    .Op_A                    (op_a),
    .Op_B                    (op_b),
    .Op_C                    (op_c),
    .Op_src                  (op_src),
    .Op_id                   (op_id),
    .Op_valid                (op_valid),
    .Op_ready                (op_ready),
    .Err_len                 (err_len),
    .Err_hdr                 (err_hdr),
    .Err_timeout             (err_timeout)
  );

  // Count high cycles of each error pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (err_len)     cnt_len++;
    if (err_hdr)     cnt_hdr++;
    if (err_timeout) cnt_to++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mkw(input logic [7:0] s, input logic [5:0] sl,
                                      input logic [5:0] i, input logic [31:0] p);
    return {s, sl, i, 12'h000, p};
  endfunction

  // Request and the following ACK->RECV edge; leaves the DUT in RECV.
  task automatic do_req(input string tag);
    req = 1'b1;
    tick;
    chk({tag, "_ack_hi"}, ack, 1'b1);
    req = 1'b0;
    tick;
    chk({tag, "_ack_lo"}, ack, 1'b0);
  endtask

  task automatic send_word(input logic [63:0] w);
    valid = 1'b1;
    data  = w;
    tick;
    valid = 1'b0;
    data  = '0;
  endtask

  task automatic handshake(input string tag);
    op_ready = 1'b1;
    tick;
    chk({tag, "_valid_drop"}, op_valid, 1'b0);
    op_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; data = '0; valid = 1'b0;
    local_id = 8'h11; op_ready = 1'b0;
    repeat (3) tick;
    chk("rst_ack", ack, 1'b0);
    chk("rst_valid", op_valid, 1'b0);
    chk("rst_ops", {op_a, op_b}, 64'h0);
    chk("rst_opc_src_id", {op_c, op_src, op_id}, 46'h0);
    chk("rst_errs", {err_len, err_hdr, err_timeout}, 3'b000);
    rst_n = 1'b1;
    tick;

    // Valid outside RECV is ignored.
    send_word(mkw(8'd1, 6'd3, 6'd1, 32'hDEAD));
    chk("idle_valid_ignored", {op_valid, ack, op_a}, 34'h0);

    // Normal 3-word packet.
    do_req("p1");
    send_word(mkw(8'd7, 6'd3, 6'd5, 32'h40200000));
    chk("p1_w1_valid", op_valid, 1'b0);
    send_word(mkw(8'd7, 6'd3, 6'd5, 32'h40800000));
    chk("p1_w2_valid", op_valid, 1'b0);
    send_word(mkw(8'd7, 6'd3, 6'd5, 32'h3F900000));
    chk("p1_valid", op_valid, 1'b1);
    chk("p1_A", op_a, 32'h40200000);
    chk("p1_B", op_b, 32'h40800000);
    chk("p1_C", op_c, 32'h3F900000);
    chk("p1_src", op_src, 8'd7);
    chk("p1_id", op_id, 6'd5);
    chk("p1_err_len", err_len, 1'b0);

    // Back-pressure with a pending request: no ack, operands stable.
    req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("bp_no_ack", ack, 1'b0);
      chk("bp_hold", {op_valid, op_a, op_b, op_c}, {1'b1, 32'h40200000, 32'h40800000, 32'h3F900000});
    end
    handshake("bp");
    chk("bp_ack_t1", ack, 1'b0);
    tick;
    chk("bp_ack_t2", ack, 1'b1);
    req = 1'b0;
    tick;
    chk("bp_ack_end", ack, 1'b0);
    chk("p1_err_counts", {cnt_len, cnt_hdr, cnt_to}, {32'd0, 32'd0, 32'd0});

    // Short packet: seq_len=2.
    send_word(mkw(8'd1, 6'd2, 6'd3, 32'd1));
    send_word(mkw(8'd1, 6'd2, 6'd3, 32'd2));
    chk("p2_valid", op_valid, 1'b1);
    chk("p2_err_len", err_len, 1'b1);
    chk("p2_ops", {op_a, op_b, op_c}, {32'd1, 32'd2, 32'd0});
    handshake("p2");
    chk("p2_err_len_pulse", err_len, 1'b0);

    // Long packet: seq_len=5, words 4 and 5 discarded.
    do_req("p3");
    for (int k = 1; k <= 5; k++) begin
      send_word(mkw(8'd2, 6'd5, 6'd9, 32'(k)));
      if (k < 5) chk("p3_not_done", op_valid, 1'b0);
    end
    chk("p3_valid", op_valid, 1'b1);
    chk("p3_err_len", err_len, 1'b1);
    chk("p3_ops", {op_a, op_b, op_c}, {32'd1, 32'd2, 32'd3});
    handshake("p3");

    // Header change on the second word.
    do_req("p4");
    send_word(mkw(8'd7, 6'd3, 6'd4, 32'd10));
    chk("p4_w1_hdr", err_hdr, 1'b0);
    send_word(mkw(8'd9, 6'd3, 6'd4, 32'd20));
    chk("p4_err_hdr", err_hdr, 1'b1);
    chk("p4_w2_valid", op_valid, 1'b0);
    send_word(mkw(8'd7, 6'd3, 6'd4, 32'd30));
    chk("p4_hdr_pulse", err_hdr, 1'b0);
    chk("p4_valid", op_valid, 1'b1);
    chk("p4_ops", {op_a, op_b, op_c, op_src}, {32'd10, 32'd20, 32'd30, 8'd7});
    chk("p4_err_len", err_len, 1'b0);
    handshake("p4");

    // Watchdog: one word then 255 idle cycles.
    do_req("p5");
    send_word(mkw(8'd7, 6'd3, 6'd1, 32'hAA));
    repeat (254) tick;
    chk("p5_to_early", err_timeout, 1'b0);
    tick;
    chk("p5_timeout", err_timeout, 1'b1);
    chk("p5_valid", op_valid, 1'b0);
    tick;
    chk("p5_to_pulse", err_timeout, 1'b0);
    chk("p5_valid_after", op_valid, 1'b0);
    do_req("p6");

    // Reset mid-RECV.
    send_word(mkw(8'd3, 6'd3, 6'd2, 32'h55));
    chk("p6_A", op_a, 32'h55);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ops", {op_a, op_src, op_id}, 46'h0);
    chk("arst_flags", {ack, op_valid, err_len, err_hdr, err_timeout}, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    chk("arst_idle", {ack, op_valid, op_a}, 34'h0);

    chk("err_len_total", cnt_len, 32'd2);
    chk("err_hdr_total", cnt_hdr, 32'd1);
    chk("err_to_total", cnt_to, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
